data_memory_bridge: RTL

Parametrised, multi-cycle successor to the core's data memory interface. Accepts one load/store per handshake from the LSU. Drives a bus with wait-state support and automatically splits accesses that cross a bus-word boundary into two aligned beats. Returns the realigned, sign/zero-extended read data, or a fault flag, on a one-cycle response pulse. Sits between the LSU and the data RAM/bus fabric.

---
 rtl/data_memory_pkg.sv | 6 +
 rtl/data_memory_bridge_lane_extender.sv | 20 ++
 rtl/data_memory_bridge.sv | 119 +++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared formats, state encoding and field indices for the data memory bridge.
package data_memory_pkg;
  typedef enum logic [1:0] {BYTE, HALF, WORD, DOUBLE} mem_format_e;
  localparam int UNSIGNED_BIT = 2;
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESPOND} bridge_state_e;
endpackage

// File: rtl/data_memory_bridge_lane_extender.sv
// lane_extender: masks an LSB-justified load to its size and sign/zero-extends it.
module lane_extender
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [2:0]            fmt,
  output logic [DATA_WIDTH-1:0] ext
);
  int   n;
  logic top;
  always_comb begin
    n = 8 << fmt[1:0];
    n = n > DATA_WIDTH ? DATA_WIDTH : n;
    top = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) if (i == n - 1) top = ~fmt[UNSIGNED_BIT] & acc[i];
    for (int i = 0; i < DATA_WIDTH; i++) ext[i] = i < n ? acc[i] : top;
  end
endmodule

// File: rtl/data_memory_bridge.sv
// data_memory_bridge: LSU-to-bus load/store bridge with wait states and two-beat split of
// boundary-crossing accesses.
module data_memory_bridge
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_WIDTH    = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      read_enable,
  input  logic                      write_enable,
  input  logic [2:0]                data_format,
  input  logic [ADDRESS_WIDTH-1:0]  address,
  input  logic [DATA_WIDTH-1:0]     write_data,
  output logic                      resp_valid,
  output logic                      resp_fault,
  output logic [DATA_WIDTH-1:0]     read_data,
  output logic [ADDRESS_WIDTH-1:0]  bus_address,
  output logic [DATA_WIDTH-1:0]     bus_write_data,
  output logic [DATA_WIDTH/8-1:0]   bus_byte_enable,
  output logic                      bus_read_enable,
  output logic                      bus_write_enable,
  input  logic                      bus_ready,
  input  logic [DATA_WIDTH-1:0]     bus_read_data
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OW    = $clog2(BYTES);
  localparam int OW1   = OW + 1;
  localparam int WB    = 2 * BYTES;
  bridge_state_e state, next;
  logic rd_q, wr_q, cross_q, fault_q;
  logic [2:0] fmt_q;
  logic [ADDRESS_WIDTH-1:0] addr_q, base;
  logic [DATA_WIDTH-1:0] wdata_q, acc, ext;
  logic [OW-1:0] in_off, off_q;
  logic [3:0] in_size, size_q;
  logic in_cross, bad;
  logic [OW+2:0] sh0;
  logic [OW+3:0] sh1;
  logic [WB-1:0] be_wide;
  logic [2*DATA_WIDTH-1:0] wd_wide;
  assign in_off   = address[OW-1:0];
  assign in_size  = 4'd1 << data_format[1:0];
  assign in_cross = (5'(in_off) + 5'(in_size)) > 5'(BYTES);
  assign bad      = (read_enable == write_enable) || (DATA_WIDTH == 32 && data_format[1:0] == DOUBLE)
                    || (!ALLOW_MISALIGNED && in_cross);
  assign off_q   = addr_q[OW-1:0];
  assign size_q  = 4'd1 << fmt_q[1:0];
  assign base    = {addr_q[ADDRESS_WIDTH-1:OW], {OW{1'b0}}};
  assign sh0     = {off_q, 3'b000};
  assign sh1     = {OW1'(BYTES) - {1'b0, off_q}, 3'b000};
  // Both beats' lanes come from one double-width shift: low half is beat 0, high half beat 1.
  assign be_wide = ((WB'(1) << size_q) - WB'(1)) << off_q;
  assign wd_wide = {{DATA_WIDTH{1'b0}}, wdata_q} << sh0;
  lane_extender #(.DATA_WIDTH(DATA_WIDTH)) u_ext (.acc(acc), .fmt(fmt_q), .ext(ext));
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cross_q <= 1'b0;
      fault_q <= 1'b0;
      fmt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      acc     <= '0;
    end else begin
      state <= next;
      if (state == IDLE && req_valid) begin
        rd_q    <= read_enable;
        wr_q    <= write_enable;
        cross_q <= in_cross;
        fault_q <= bad;
        fmt_q   <= data_format;
        addr_q  <= address;
        wdata_q <= write_data;
        acc     <= '0;
      end
      if (state == BEAT0 && bus_ready) acc <= bus_read_data >> sh0;
      if (state == BEAT1 && bus_ready) acc <= acc | (bus_read_data << sh1);
    end
  end
  always_comb begin
    next             = state;
    bus_address      = '0;
    bus_byte_enable  = '0;
    bus_write_data   = '0;
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    case (state)
      IDLE: next = req_valid ? (bad ? RESPOND : BEAT0) : IDLE;
      BEAT0: begin
        bus_address      = base;
        bus_byte_enable  = be_wide[BYTES-1:0];
        bus_write_data   = wd_wide[DATA_WIDTH-1:0];
        bus_read_enable  = rd_q;
        bus_write_enable = wr_q;
        next             = bus_ready ? (cross_q ? BEAT1 : RESPOND) : BEAT0;
      end
      BEAT1: begin
        bus_address      = base + ADDRESS_WIDTH'(BYTES);
        bus_byte_enable  = be_wide[WB-1:BYTES];
        bus_write_data   = wd_wide[2*DATA_WIDTH-1:DATA_WIDTH];
        bus_read_enable  = rd_q;
        bus_write_enable = wr_q;
        next             = bus_ready ? RESPOND : BEAT1;
      end
      default: next = IDLE;
    endcase
  end
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESPOND;
  assign resp_fault = resp_valid & fault_q;
  assign read_data  = (resp_valid && rd_q && !fault_q) ? ext : '0;
endmodule
